// File: rtl/parking_gate_controller_if.sv
// Event/gate bundle between the barrier hardware, the parking system and the
// gate controller.
//   Sensor side : entry_req/entry_is_uni, exit_req/exit_is_uni (levels)
//   System side : vacancy flags, parked-car counts (into the controller)
//   Event side  : car_entered/car_exited strobes with class qualifiers
//   Gate side   : barrier drives, one-cycle denial pulses, busy
// The master modport is the controller; the slave modport is its surroundings.
interface parking_gate_controller_if;
   logic       entry_req;
   logic       entry_is_uni;
   logic       exit_req;
   logic       exit_is_uni;
   logic       uni_is_vacated_space;
   logic       free_is_vacated_space;
   logic [9:0] uni_parked_car;
   logic [9:0] free_parked_car;
   logic       car_entered;
   logic       is_uni_car_entered;
   logic       car_exited;
   logic       is_uni_car_exited;
   logic       entry_gate_open;
   logic       exit_gate_open;
   logic       entry_denied;
   logic       exit_denied;
   logic       busy;

   modport master (
      input  entry_req, entry_is_uni, exit_req, exit_is_uni,
      input  uni_is_vacated_space, free_is_vacated_space,
      input  uni_parked_car, free_parked_car,
      output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
      output entry_gate_open, exit_gate_open, entry_denied, exit_denied, busy
   );

   modport slave (
      output entry_req, entry_is_uni, exit_req, exit_is_uni,
      output uni_is_vacated_space, free_is_vacated_space,
      output uni_parked_car, free_parked_car,
      input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
      input  entry_gate_open, exit_gate_open, entry_denied, exit_denied, busy
   );
endinterface

// File: rtl/parking_gate_controller.sv
// Gate-side driver of the parking system's event interface.
// Two identical barrier FSMs (entry, exit) decide admission, hold the barrier
// open, then emit one serialized event strobe each through a shared arbiter
// that enforces a minimum low gap between strobes (exit has priority).
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : parking_gate_controller_if.master (sensors, system status,
//                event strobes, barrier drives, denial pulses, busy)

// One barrier channel: IDLE -> CHECK -> OPEN -> COMMIT -> IDLE, or CHECK -> DENY.
// COMMIT first waits for the strobe slot with the gate still open, then strobes.
module parking_gate_fsm #(
   parameter int unsigned GATE_OPEN_CYCLES = 8,
   parameter int unsigned STROBE_CYCLES    = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic req_edge,    // accepted only while IDLE
   input  logic is_uni,      // class of the waiting car, latched in CHECK
   input  logic admit,       // admission decision, meaningful in CHECK
   input  logic grant,       // strobe slot granted this cycle
   output logic strobe_req,  // asking for the strobe slot
   output logic gate_open,
   output logic strobe,
   output logic is_uni_q,
   output logic denied,
   output logic active
);
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CHECK  = 3'd1,
      OPEN   = 3'd2,
      COMMIT = 3'd3,
      DENY   = 3'd4
   } state_t;

   localparam logic [7:0] OPEN_LAST   = 8'(GATE_OPEN_CYCLES - 1);
   localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYCLES - 1);

   state_t     state_r, state_nxt_s;
   logic [7:0] cnt_r, cnt_nxt_s;
   logic       strobing_r, strobing_nxt_s;
   logic       gate_nxt_s, strobe_nxt_s, denied_nxt_s, active_nxt_s;

   // The slot is requested already on the last OPEN cycle so an uncontended
   // strobe follows the gate with no dead cycle.
   assign strobe_req = ((state_r == OPEN) && (cnt_r == OPEN_LAST)) ||
                       ((state_r == COMMIT) && !strobing_r);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         cnt_r      <= 8'd0;
         strobing_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         cnt_r      <= cnt_nxt_s;
         strobing_r <= strobing_nxt_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt_s    = state_r;
      cnt_nxt_s      = cnt_r;
      strobing_nxt_s = strobing_r;
      case (state_r)
         IDLE: begin
            cnt_nxt_s      = 8'd0;
            strobing_nxt_s = 1'b0;
            if (req_edge) state_nxt_s = CHECK;
            else          state_nxt_s = IDLE;
         end
         CHECK: begin
            cnt_nxt_s = 8'd0;
            if (admit) state_nxt_s = OPEN;
            else       state_nxt_s = DENY;
         end
         OPEN: begin
            if (cnt_r == OPEN_LAST) begin
               state_nxt_s    = COMMIT;
               cnt_nxt_s      = 8'd0;
               strobing_nxt_s = grant;
            end else begin
               cnt_nxt_s = cnt_r + 8'd1;
            end
         end
         COMMIT: begin
            if (!strobing_r) begin
               cnt_nxt_s      = 8'd0;
               strobing_nxt_s = grant;
            end else if (cnt_r == STROBE_LAST) begin
               state_nxt_s    = IDLE;
               cnt_nxt_s      = 8'd0;
               strobing_nxt_s = 1'b0;
            end else begin
               cnt_nxt_s = cnt_r + 8'd1;
            end
         end
         DENY: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s    = IDLE;
            cnt_nxt_s      = 8'd0;
            strobing_nxt_s = 1'b0;
         end
      endcase
   end

   // Output decode from the next state so the drives can be registered
   always_comb begin
      gate_nxt_s   = 1'b0;
      strobe_nxt_s = 1'b0;
      denied_nxt_s = 1'b0;
      active_nxt_s = (state_nxt_s != IDLE);
      case (state_nxt_s)
         OPEN: begin
            gate_nxt_s = 1'b1;
         end
         COMMIT: begin
            gate_nxt_s   = !strobing_nxt_s;
            strobe_nxt_s = strobing_nxt_s;
         end
         DENY: begin
            denied_nxt_s = 1'b1;
         end
         default: begin
            gate_nxt_s   = 1'b0;
            strobe_nxt_s = 1'b0;
            denied_nxt_s = 1'b0;
         end
      endcase
   end

   // Output registers; the class qualifier only moves at the end of CHECK
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gate_open <= 1'b0;
         strobe    <= 1'b0;
         denied    <= 1'b0;
         active    <= 1'b0;
         is_uni_q  <= 1'b0;
      end else begin
         gate_open <= gate_nxt_s;
         strobe    <= strobe_nxt_s;
         denied    <= denied_nxt_s;
         active    <= active_nxt_s;
         if (state_r == CHECK) is_uni_q <= is_uni;
         else                  is_uni_q <= is_uni_q;
      end
   end
endmodule

module parking_gate_controller #(
   parameter int unsigned GATE_OPEN_CYCLES = 8,
   parameter int unsigned STROBE_CYCLES    = 2,
   parameter int unsigned GAP_CYCLES       = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   parking_gate_controller_if.master  bus
);
   localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

   logic       entry_req_r, exit_req_r;
   logic       entry_edge_s, exit_edge_s;
   logic       entry_admit_s, exit_admit_s;
   logic       entry_wants_s, exit_wants_s;
   logic       entry_grant_s, exit_grant_s;
   logic       entry_strobe_s, exit_strobe_s;
   logic       entry_active_s, exit_active_s;
   logic       any_strobe_s, gap_ok_s;
   logic [3:0] gap_cnt_r;

   // Sensor levels registered once for edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         entry_req_r <= 1'b0;
         exit_req_r  <= 1'b0;
      end else begin
         entry_req_r <= bus.entry_req;
         exit_req_r  <= bus.exit_req;
      end
   end

   assign entry_edge_s  = bus.entry_req & ~entry_req_r;
   assign exit_edge_s   = bus.exit_req  & ~exit_req_r;
   assign entry_admit_s = bus.entry_is_uni ? bus.uni_is_vacated_space
                                           : bus.free_is_vacated_space;
   assign exit_admit_s  = bus.exit_is_uni ? (bus.uni_parked_car  != 10'd0)
                                          : (bus.free_parked_car != 10'd0);

   // Gap counter: reloaded while any strobe is high, then counts low cycles down.
   // A grant in a cycle makes the strobe rise next cycle, so the gap has run
   // out once the counter reaches 1 with both strobes low.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                   gap_cnt_r <= 4'd0;
      else if (any_strobe_s)       gap_cnt_r <= GAP_LOAD;
      else if (gap_cnt_r != 4'd0)  gap_cnt_r <= gap_cnt_r - 4'd1;
      else                         gap_cnt_r <= gap_cnt_r;
   end

   assign any_strobe_s  = entry_strobe_s | exit_strobe_s;
   assign gap_ok_s      = !any_strobe_s && (gap_cnt_r <= 4'd1);
   assign exit_grant_s  = exit_wants_s & gap_ok_s;
   assign entry_grant_s = entry_wants_s & gap_ok_s & ~exit_wants_s;

   parking_gate_fsm #(
      .GATE_OPEN_CYCLES (GATE_OPEN_CYCLES),
      .STROBE_CYCLES    (STROBE_CYCLES)
   ) u_entry (
      .clk        (clk),
      .reset      (reset),
      .req_edge   (entry_edge_s),
      .is_uni     (bus.entry_is_uni),
      .admit      (entry_admit_s),
      .grant      (entry_grant_s),
      .strobe_req (entry_wants_s),
      .gate_open  (bus.entry_gate_open),
      .strobe     (entry_strobe_s),
      .is_uni_q   (bus.is_uni_car_entered),
      .denied     (bus.entry_denied),
      .active     (entry_active_s)
   );

   parking_gate_fsm #(
      .GATE_OPEN_CYCLES (GATE_OPEN_CYCLES),
      .STROBE_CYCLES    (STROBE_CYCLES)
   ) u_exit (
      .clk        (clk),
      .reset      (reset),
      .req_edge   (exit_edge_s),
      .is_uni     (bus.exit_is_uni),
      .admit      (exit_admit_s),
      .grant      (exit_grant_s),
      .strobe_req (exit_wants_s),
      .gate_open  (bus.exit_gate_open),
      .strobe     (exit_strobe_s),
      .is_uni_q   (bus.is_uni_car_exited),
      .denied     (bus.exit_denied),
      .active     (exit_active_s)
   );

   assign bus.car_entered = entry_strobe_s;
   assign bus.car_exited  = exit_strobe_s;
   assign bus.busy        = entry_active_s | exit_active_s;
endmodule

// File: doc/parking_gate_controller.md
Name: parking_gate_controller

Overview:
- Gate-side driver of the parking system's event interface.
- Accepts raw entry and exit requests from the barrier sensors and decides admission from the system's vacancy flags and occupancy counts.
- Operates each barrier, then issues clean, serialized entry/exit strobes (car_entered/car_exited plus class bits) to the parking system.
- Sits between the gate hardware and ParkingSystem, and is the only source of ParkingSystem's event inputs.

Parameters:
GATE_OPEN_CYCLES, 8, cycles a barrier stays open before the event is committed (range 1..255)
STROBE_CYCLES, 2, high time of car_entered / car_exited per committed event (range 1..15)
GAP_CYCLES, 2, minimum low cycles between the end of any strobe and the start of the next, either channel (range 1..15)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
entry_req  input  1  entry sensor level; rising edge = car waiting at entry
entry_is_uni  input  1  class of waiting entry car (1 = university)
exit_req  input  1  exit sensor level; rising edge = car waiting at exit
exit_is_uni  input  1  class of exiting car
uni_is_vacated_space  input  1  from ParkingSystem: university zone has room
free_is_vacated_space  input  1  from ParkingSystem: free zone has room
uni_parked_car  input  10  from ParkingSystem: university cars parked
free_parked_car  input  10  from ParkingSystem: free cars parked
car_entered  output  1  entry event strobe to ParkingSystem
is_uni_car_entered  output  1  class qualifier for car_entered
car_exited  output  1  exit event strobe to ParkingSystem
is_uni_car_exited  output  1  class qualifier for car_exited
entry_gate_open  output  1  entry barrier drive
exit_gate_open  output  1  exit barrier drive
entry_denied  output  1  one-cycle pulse: entry refused (zone full)
exit_denied  output  1  one-cycle pulse: exit refused (class count is 0)
busy  output  1  either gate FSM is not IDLE

Behaviour:
- Reset: all outputs 0, both FSMs IDLE, gap counter cleared. Asserting reset mid-operation drops strobes and gate drives immediately (asynchronously), with no partial event.
- Edge detect:
  - entry_req and exit_req are registered once; a request is a sampled 0->1 transition.
  - Edges arriving while the owning FSM is not IDLE are ignored, not queued.
- Entry FSM states: IDLE, CHECK, OPEN, COMMIT, DENY.
  - IDLE -> CHECK on the entry edge.
  - CHECK (1 cycle):
    - Latch entry_is_uni into is_uni_car_entered.
    - Admit if (uni ? uni_is_vacated_space : free_is_vacated_space).
    - Admit -> OPEN; else -> DENY.
  - OPEN: entry_gate_open=1 for exactly GATE_OPEN_CYCLES cycles, then -> COMMIT.
  - COMMIT: wait for the strobe grant, then drive car_entered=1 for STROBE_CYCLES cycles, then -> IDLE.
  - DENY: entry_denied=1 for 1 cycle, then -> IDLE.
- Exit FSM: identical structure.
  - Admit if the class count is nonzero: uni_parked_car!=0 or free_parked_car!=0.
  - Drives exit_gate_open, car_exited, is_uni_car_exited, exit_denied.
- Class qualifiers:
  - Change only in CHECK.
  - Are therefore stable at least GATE_OPEN_CYCLES before and throughout their strobe.
  - Hold their value after the strobe until the next CHECK.
- Strobe arbiter:
  - Only one strobe is high at any time. car_entered and car_exited are never simultaneously 1.
  - Grant requires the gap counter to have expired: GAP_CYCLES low cycles since the last strobe fell; free after reset.
  - If both FSMs are in COMMIT and eligible in the same cycle, exit wins and entry waits.
  - A waiting FSM keeps its gate open (gate output stays 1) until granted.
- Vacancy and counts are sampled only in CHECK. Changes during OPEN do not revoke an admission.
- Strobes are level pulses returning to 0. One committed event = exactly one 0->1 transition on its strobe.
- busy = (entry FSM != IDLE) | (exit FSM != IDLE).
- Timing, entry edge sampled at cycle N, no contention:
  - CHECK at N+1.
  - entry_gate_open over N+2..N+1+GATE_OPEN_CYCLES.
  - car_entered over the next STROBE_CYCLES cycles.
  - IDLE on the following cycle.

Test Plan:
- Reset, then uni entry with uni_is_vacated_space=1, edge at N, defaults -> CHECK N+1; entry_gate_open N+2..N+9; car_entered=1, is_uni_car_entered=1 at N+10..N+11; busy=0 at N+12.
- Free entry with free_is_vacated_space=0 -> entry_denied pulse at N+2; no gate, no strobe; a second edge at N+5 is accepted.
- Exit with is_uni=1 and uni_parked_car=0 -> exit_denied at N+2. Repeat with uni_parked_car=5 -> car_exited=1, is_uni_car_exited=1 for 2 cycles.
- Entry and exit edges in the same cycle, both admitted -> car_exited N+10..N+11; entry gate held open; car_entered N+14..N+15 (GAP_CYCLES=2); strobes never overlap.
- 300 back-to-back entry edges, each after IDLE -> exactly 300 car_entered rising edges; edges during a busy FSM produce none.
- reset asserted during OPEN and during strobe -> all outputs 0 immediately; a fresh request after release completes normally.
